data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-port data memory behind a MEM-stage request interface.
//               Reads complete in one cycle and may issue back-to-back.
//               Writes are captured in IDLE and committed one cycle later
//               in COMMIT, with big-endian byte enables (lane 0 = [31:24]).
//               Requests whose address lies beyond the array, or whose
//               write bytes would spill past the word, raise DM_err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK                  in   1   clock, all state on rising edge
//   RESET                in   1   synchronous active-high reset
//   data_address_2DM     in  32   byte address
//   data_write_2DM       in  32   lane-aligned write data
//   data_write_size_2DM  in   2   byte count: 0=4, 1=1, 2=2, 3=3
//   MemRead_2DM          in   1   read request
//   MemWrite_2DM         in   1   write request
//   data_read_fDM        out 32   registered read data
//   DM_valid             out  1   pulse: data_read_fDM holds new data
//   DM_busy              out  1   write commit in progress
//   DM_err               out  1   pulse: request out of range / misaligned
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_BITS = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    output logic [31:0] data_read_fDM,
    output logic        DM_valid,
    output logic        DM_busy,
    output logic        DM_err
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   valid_q, valid_d;
    logic                   err_q,   err_d;
    logic [ADDR_BITS-1:0]   widx_q,  widx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q,    be_d;

    logic [31:0]            mem_q [c_DEPTH];

    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_oor;
    logic [1:0]             w_off;
    logic [2:0]             w_nbytes;
    logic [2:0]             w_end;
    logic                   w_misalign;
    logic [3:0]             w_be;

    // ------------------------------------------------------------------
    // Address decode and byte-enable generation
    // ------------------------------------------------------------------
    assign w_idx = data_address_2DM[ADDR_BITS+1:2];
    assign w_off = data_address_2DM[1:0];
    // Any address bit above the word index makes the request out of range.
    assign w_oor = (data_address_2DM >> (ADDR_BITS + 2)) != 32'd0;

    always_comb begin
        w_nbytes   = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
        // One past the last lane touched; max 3+4 = 7 fits in 3 bits.
        w_end      = {1'b0, w_off} + w_nbytes;
        w_misalign = (w_end > 3'd4);
        w_be       = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            w_be[l] = (3'(l) >= {1'b0, w_off}) && (3'(l) < w_end);
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        be_d    = be_q;

        case (state_q)
            ST_IDLE: begin
                if (MemRead_2DM) begin
                    valid_d = 1'b1;
                    if (w_oor) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        // Memory is only written in COMMIT, so a read paired
                        // with a write here naturally returns the old word.
                        rdata_d = mem_q[w_idx];
                    end
                end
                if (MemWrite_2DM) begin
                    if (w_oor || w_misalign) begin
                        err_d = 1'b1;
                    end else begin
                        widx_d  = w_idx;
                        wdata_d = data_write_2DM;
                        be_d    = w_be;
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                // Requests are ignored here; the initiator holds them.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory array: no reset; a reset during COMMIT drops the write.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET && (state_q == ST_COMMIT)) begin
            for (int l = 0; l < 4; l++) begin
                if (be_q[l]) begin
                    mem_q[widx_q][31-8*l -: 8] <= wdata_q[31-8*l -: 8];
                end
            end
        end
    end

    assign data_read_fDM = rdata_q;
    assign DM_valid      = valid_q;
    assign DM_err        = err_q;
    assign DM_busy       = (state_q == ST_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed scoreboard bench for data_mem_responder. Stimulus
//               pushes expected responses into a queue; a monitor pops and
//               compares whenever DM_valid or DM_err is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] data_address_2DM;
    logic [31:0] data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        MemRead_2DM;
    logic        MemWrite_2DM;
    logic [31:0] data_read_fDM;
    logic        DM_valid;
    logic        DM_busy;
    logic        DM_err;

    data_mem_responder #(.ADDR_BITS(10)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .data_address_2DM    (data_address_2DM),
        .data_write_2DM      (data_write_2DM),
        .data_write_size_2DM (data_write_size_2DM),
        .MemRead_2DM         (MemRead_2DM),
        .MemWrite_2DM        (MemWrite_2DM),
        .data_read_fDM       (data_read_fDM),
        .DM_valid            (DM_valid),
        .DM_busy             (DM_busy),
        .DM_err              (DM_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one queue entry per output event
    always @(negedge CLK) begin
        exp_t e;
        if (DM_valid === 1'b1 || DM_err === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: valid=%b err=%b data=%h, expected none (t=%0t)",
                         DM_valid, DM_err, data_read_fDM, $time);
            end else begin
                e = q.pop_front();
                check("mon_valid", {31'd0, DM_valid}, {31'd0, e.valid});
                check("mon_err",   {31'd0, DM_err},   {31'd0, e.err});
                if (e.valid) check("mon_data", data_read_fDM, e.data);
            end
        end
    end

    function automatic exp_t mk(input logic v, input logic er, input logic [31:0] d);
        exp_t e;
        e.valid = v;
        e.err   = er;
        e.data  = d;
        return e;
    endfunction

    // All tasks start and end at a negedge.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
        data_address_2DM = a;
        MemRead_2DM      = 1'b1;
        q.push_back(mk(1'b1, exp_err, exp_d));
        @(posedge CLK); @(negedge CLK);
        MemRead_2DM      = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                      input logic also_rd, input logic [31:0] rd_exp, input logic exp_err);
        data_address_2DM    = a;
        data_write_2DM      = d;
        data_write_size_2DM = sz;
        MemWrite_2DM        = 1'b1;
        MemRead_2DM         = also_rd;
        if (also_rd || exp_err) q.push_back(mk(also_rd, exp_err, also_rd ? rd_exp : 32'd0));
        @(posedge CLK); @(negedge CLK);
        MemWrite_2DM = 1'b0;
        MemRead_2DM  = 1'b0;
        check("busy_T1", {31'd0, DM_busy}, {31'd0, ~exp_err});
        if (!exp_err) begin
            @(posedge CLK); @(negedge CLK);
            check("busy_T2", {31'd0, DM_busy}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET               = 1'b1;
        data_address_2DM    = 32'd0;
        data_write_2DM      = 32'd0;
        data_write_size_2DM = 2'd0;
        MemRead_2DM         = 1'b0;
        MemWrite_2DM        = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_data",  data_read_fDM, 32'd0);
        check("rst_valid", {31'd0, DM_valid}, 32'd0);
        check("rst_busy",  {31'd0, DM_busy},  32'd0);
        check("rst_err",   {31'd0, DM_err},   32'd0);
        RESET = 1'b0;
        idle(1);

        // Preload mem[4], mem[5] through the write port
        wr(32'h10, 32'h11223344, 2'd0, 1'b0, 32'd0, 1'b0);
        wr(32'h14, 32'hCAFEF00D, 2'd0, 1'b0, 32'd0, 1'b0);

        // Basic read, then idle hold
        rd(32'h10, 32'h11223344, 1'b0);
        idle(1);
        check("hold_valid", {31'd0, DM_valid}, 32'd0);
        check("hold_data",  data_read_fDM, 32'h11223344);

        // Back-to-back reads
        rd(32'h14, 32'hCAFEF00D, 1'b0);
        rd(32'h10, 32'h11223344, 1'b0);

        // Byte and 3-byte writes
        wr(32'h11, 32'h00EE0000, 2'd1, 1'b0, 32'd0, 1'b0);
        rd(32'h10, 32'h11EE3344, 1'b0);
        wr(32'h11, 32'h00A1B2C3, 2'd3, 1'b0, 32'd0, 1'b0);
        rd(32'h10, 32'h11A1B2C3, 1'b0);

        // Misaligned halfword: error, no busy, word unchanged
        wr(32'h13, 32'h0000FFFF, 2'd2, 1'b0, 32'd0, 1'b1);
        rd(32'h10, 32'h11A1B2C3, 1'b0);

        // Out-of-range read and write (0x1010 would alias index 4)
        rd(32'h0001_0000, 32'd0, 1'b1);
        wr(32'h0000_1010, 32'hDEADBEEF, 2'd0, 1'b0, 32'd0, 1'b1);
        rd(32'h10, 32'h11A1B2C3, 1'b0);

        // Full word write
        wr(32'h10, 32'hAABBCCDD, 2'd0, 1'b0, 32'd0, 1'b0);
        rd(32'h10, 32'hAABBCCDD, 1'b0);

        // Read-before-write
        wr(32'h10, 32'h01020304, 2'd0, 1'b1, 32'hAABBCCDD, 1'b0);
        rd(32'h10, 32'h01020304, 1'b0);

        // Halfword at lanes 2-3, byte at lane 0
        wr(32'h12, 32'h0000BEEF, 2'd2, 1'b0, 32'd0, 1'b0);
        rd(32'h10, 32'h0102BEEF, 1'b0);
        wr(32'h10, 32'h7F000000, 2'd1, 1'b0, 32'd0, 1'b0);
        rd(32'h10, 32'h7F02BEEF, 1'b0);

        // Read held across a busy cycle is sampled only after COMMIT
        data_address_2DM    = 32'h14;
        data_write_2DM      = 32'h55667788;
        data_write_size_2DM = 2'd0;
        MemWrite_2DM        = 1'b1;
        @(posedge CLK); @(negedge CLK);
        MemWrite_2DM = 1'b0;
        check("hold_busy", {31'd0, DM_busy}, 32'd1);
        MemRead_2DM  = 1'b1;
        q.push_back(mk(1'b1, 1'b0, 32'h55667788));
        @(posedge CLK); @(negedge CLK);
        check("ignored_rd_valid", {31'd0, DM_valid}, 32'd0);
        check("ignored_rd_busy",  {31'd0, DM_busy},  32'd0);
        @(posedge CLK); @(negedge CLK);
        MemRead_2DM = 1'b0;

        // Reset during COMMIT discards the write; read during reset ignored
        data_address_2DM    = 32'h10;
        data_write_2DM      = 32'hFFFFFFFF;
        data_write_size_2DM = 2'd0;
        MemWrite_2DM        = 1'b1;
        @(posedge CLK); @(negedge CLK);
        MemWrite_2DM = 1'b0;
        check("rc_busy_pre", {31'd0, DM_busy}, 32'd1);
        RESET       = 1'b1;
        MemRead_2DM = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("rc_data",  data_read_fDM, 32'd0);
        check("rc_valid", {31'd0, DM_valid}, 32'd0);
        check("rc_busy",  {31'd0, DM_busy},  32'd0);
        check("rc_err",   {31'd0, DM_err},   32'd0);
        RESET       = 1'b0;
        MemRead_2DM = 1'b0;
        idle(1);
        rd(32'h10, 32'h7F02BEEF, 1'b0);

        idle(3);
        check("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
